// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu -- load/store unit for the milano EX stage
//
// Takes the effective address from the ALU adder, the store data and the
// access type, and runs one data-bus transaction:
//   1. a req/gnt handshake
//   2. a wait for rvalid
// Load data is aligned and sign/zero-extended, then written back to the
// register file with a single-cycle strobe. Only one access is in flight at a
// time; the core stalls while busy_o is high.
//
// Optional feature: define LSU_TIMEOUT_EN to enable a response timeout. While
// waiting for rvalid, an 8-bit counter advances each cycle. When it reaches
// TIMEOUT_CYCLES with no rvalid, the LSU pulses err_o and returns to idle.
// Without the macro, err_o is tied to 0 and the LSU waits indefinitely.
//
// Ports
//   clk_i, rst_i         clock (rising edge), synchronous active-high reset
//   req_valid_i/ready_o  EX-side handshake; ready while idle
//   mem_we_i             1 = store, 0 = load
//   mem_size_i           0 = byte, 1 = half, 2 = word, 3 = illegal
//   mem_unsigned_i       zero-extend loaded data (LBU/LHU)
//   addr_i, wdata_i      effective address, store data (rs2)
//   rd_addr_i            load destination register
//   data_req_o/gnt_i     bus request / grant
//   data_addr_o          word-aligned bus address
//   data_we_o/be_o       bus write enable / byte enables
//   data_wdata_o         store data replicated into every lane
//   data_rvalid_i/rdata_i response strobe (loads and store acks) / read data
//   lsu_rd_we_o/waddr_o/wdata_o  one-cycle register write-back
//   busy_o               transaction in progress
//   misaligned_o         1-cycle pulse: misaligned or illegal access dropped
//   err_o                1-cycle pulse: response timeout
// ---------------------------------------------------------------------------
module lsu #(
`ifdef LSU_TIMEOUT_EN
    parameter int unsigned TIMEOUT_CYCLES = 64
`endif
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_size_i,
    input  logic        mem_unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rd_addr_i,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    output logic        lsu_rd_we_o,
    output logic [4:0]  lsu_rd_waddr_o,
    output logic [31:0] lsu_rd_wdata_o,
    output logic        busy_o,
    output logic        misaligned_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } state_e;

    state_e      state_q, state_d;

    logic        we_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [4:0]  rd_q;

    logic        rd_we_q;
    logic [4:0]  rd_waddr_q;
    logic [31:0] rd_wdata_q;
    logic        misaligned_q;
    logic        err_q;

    logic        accept;
    logic        misaligned;
    logic        timeout;
    logic        rsp_wb;
    logic [3:0]  be;
    logic [31:0] wdata_lane;
    logic [31:0] load_data;

    assign accept = req_valid_i && (state_q == IDLE);

    // The alignment check uses the raw inputs, so a bad access is rejected
    // in its accept cycle and never reaches the bus.
    always_comb begin
        misaligned = 1'b0;
        case (mem_size_i)
            2'd1:    misaligned = addr_i[0];
            2'd2:    misaligned = (addr_i[1:0] != 2'b00);
            2'd3:    misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    logic [7:0] tmo_cnt_q, tmo_cnt_d;

    // The counter is held at zero outside WAIT_RSP, so it always starts from
    // zero on entry. Each WAIT_RSP cycle then advances it by one.
    always_comb begin
        tmo_cnt_d = 8'd0;
        if (state_q == WAIT_RSP) begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_cnt_q <= 8'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    // Fires in the last permitted WAIT_RSP cycle if rvalid still has not arrived.
    assign timeout = (state_q == WAIT_RSP) && !data_rvalid_i &&
                     (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // Next-state logic. An illegal access is dropped while the FSM stays in
    // IDLE. rvalid is honoured only in WAIT_RSP, which discards any response
    // that arrives late after a reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept && !misaligned) state_d = REQ;
            REQ:      if (data_gnt_i) state_d = WAIT_RSP;
            WAIT_RSP: if (data_rvalid_i || timeout) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Byte enables and lane-replicated store data come from the registered
    // request. They stay stable for as long as the grant is withheld.
    always_comb begin
        be         = 4'b1111;
        wdata_lane = wdata_q;
        case (size_q)
            2'd0: begin
                be         = 4'b0001 << addr_q[1:0];
                wdata_lane = {4{wdata_q[7:0]}};
            end
            2'd1: begin
                be         = addr_q[1] ? 4'b1100 : 4'b0011;
                wdata_lane = {2{wdata_q[15:0]}};
            end
            default: begin
                be         = 4'b1111;
                wdata_lane = wdata_q;
            end
        endcase
    end

    // Select the addressed byte or halfword lane, then sign- or zero-extend it.
    always_comb begin
        load_data = data_rdata_i;
        case (size_q)
            2'd0: begin
                load_data = {{24{!unsigned_q && data_rdata_i[{addr_q[1:0], 3'b111}]}},
                             data_rdata_i[{addr_q[1:0], 3'b000} +: 8]};
            end
            2'd1: begin
                load_data = {{16{!unsigned_q && data_rdata_i[{addr_q[1], 4'b1111}]}},
                             data_rdata_i[{addr_q[1], 4'b0000} +: 16]};
            end
            default: load_data = data_rdata_i;
        endcase
    end

    // Only a load with a non-zero destination writes back; x0 is never written.
    assign rsp_wb = (state_q == WAIT_RSP) && data_rvalid_i && !we_q && (rd_q != 5'd0);

    // State, captured request fields and registered status pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            size_q       <= 2'd0;
            unsigned_q   <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            rd_q         <= 5'd0;
            rd_we_q      <= 1'b0;
            rd_waddr_q   <= 5'd0;
            rd_wdata_q   <= 32'd0;
            misaligned_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            misaligned_q <= accept && misaligned;
            err_q        <= timeout;
            rd_we_q      <= rsp_wb;
            if (accept) begin
                we_q       <= mem_we_i;
                size_q     <= mem_size_i;
                unsigned_q <= mem_unsigned_i;
                addr_q     <= addr_i;
                wdata_q    <= wdata_i;
                rd_q       <= rd_addr_i;
            end
            if (rsp_wb) begin
                rd_waddr_q <= rd_q;
                rd_wdata_q <= load_data;
            end
        end
    end

    // Bus fields are driven only while requesting; otherwise they read as
    // zero, so the bus is quiet whenever no request is outstanding.
    assign req_ready_o    = (state_q == IDLE);
    assign busy_o         = (state_q != IDLE);
    assign data_req_o     = (state_q == REQ);
    assign data_addr_o    = data_req_o ? {addr_q[31:2], 2'b00} : 32'd0;
    assign data_we_o      = data_req_o && we_q;
    assign data_be_o      = data_req_o ? be : 4'b0000;
    assign data_wdata_o   = data_req_o ? wdata_lane : 32'd0;
    assign lsu_rd_we_o    = rd_we_q;
    assign lsu_rd_waddr_o = rd_waddr_q;
    assign lsu_rd_wdata_o = rd_wdata_q;
    assign misaligned_o   = misaligned_q;
    assign err_o          = err_q;

endmodule
